zigzag_coeff_buffer: RTL and testbench

- Upstream neighbour of the inverse quantizer in the camera decoder's inverse quant/transform path.
- Accepts 4x4-block quantized coefficients serially in scan order from the entropy decoder, zero-fills after end-of-block, and reorders them to raster order.
- Streams the reordered coefficients, one per cycle, with the block's QP attached.
- Ping-pong double buffering sustains 1 coefficient/cycle.

---
 rtl/zigzag_coeff_buffer.sv | 116 +++++++++++
 tb/tb_zigzag_coeff_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_coeff_buffer.sv
// zigzag_coeff_buffer: ping-pong 4x4 buffer that reorders scan-order coefficients to raster order, zero-filling after EOB.
// Optional COEFF_FIELD_SCAN_EN adds in_field to select the field scan table per block.
module zigzag_coeff_buffer #(
    parameter int COEFF_WIDTH = 16,
    parameter int QP_WIDTH    = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [COEFF_WIDTH-1:0] in_coeff,
    input  logic                          in_eob,
    input  logic        [QP_WIDTH-1:0]    in_qp,
`ifdef COEFF_FIELD_SCAN_EN
    input  logic                          in_field,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [COEFF_WIDTH-1:0] out_coeff,
    output logic        [QP_WIDTH-1:0]    out_qp,
    output logic                          out_last
);
    // scan index k -> raster position, entry k in bits [4k+3:4k]
    localparam logic [63:0] ZIGZAG = {4'd15, 4'd14, 4'd11, 4'd7, 4'd10, 4'd13, 4'd12, 4'd9,
                                      4'd6, 4'd3, 4'd2, 4'd5, 4'd8, 4'd4, 4'd1, 4'd0};
    localparam logic [63:0] FIELD  = {4'd15, 4'd11, 4'd7, 4'd3, 4'd14, 4'd10, 4'd6, 4'd2,
                                      4'd13, 4'd9, 4'd5, 4'd12, 4'd8, 4'd1, 4'd4, 4'd0};

    logic signed [COEFF_WIDTH-1:0] mem [2][16];
    logic [15:0]         mask [2];
    logic [QP_WIDTH-1:0] qp [2];
    logic [1:0]          full;
    logic                wr_ptr, rd_ptr, ld_ptr;
    logic [3:0]          k, r, pos;
    logic                fld, acc, done, freeing, adv, avail, byp, hit;

`ifdef COEFF_FIELD_SCAN_EN
    logic [1:0] field;
    assign fld = (k == 4'd0) ? in_field : field[wr_ptr];
`else
    assign fld = 1'b0;
`endif

    // ld_ptr/r name the next coefficient to load into the output register;
    // rd_ptr names the bank whose coefficient currently sits in that register.
    always_comb begin
        pos     = fld ? FIELD[{k, 2'b00} +: 4] : ZIGZAG[{k, 2'b00} +: 4];
        freeing = out_valid && out_ready && out_last;
        in_ready = !full[wr_ptr] || (freeing && rd_ptr == wr_ptr);
        acc     = in_valid && in_ready;
        done    = acc && (in_eob || k == 4'd15);
        byp     = acc && wr_ptr == ld_ptr;
        hit     = byp && pos == r;
        adv     = !out_valid || out_ready;
        avail   = full[ld_ptr] || (done && wr_ptr == ld_ptr);
    end

    always_ff @(posedge clk) begin
        if (acc)
            mem[wr_ptr][pos] <= in_coeff;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= '0;
            mask[0]   <= '0;
            mask[1]   <= '0;
            qp[0]     <= '0;
            qp[1]     <= '0;
`ifdef COEFF_FIELD_SCAN_EN
            field     <= '0;
`endif
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            ld_ptr    <= 1'b0;
            k         <= '0;
            r         <= '0;
            out_valid <= 1'b0;
            out_coeff <= '0;
            out_qp    <= '0;
            out_last  <= 1'b0;
        end else begin
            if (freeing) begin
                full[rd_ptr] <= 1'b0;
                mask[rd_ptr] <= '0;
                rd_ptr       <= !rd_ptr;
            end
            if (acc) begin
                mask[wr_ptr][pos] <= 1'b1;
                if (k == 4'd0) begin
                    qp[wr_ptr] <= in_qp;
`ifdef COEFF_FIELD_SCAN_EN
                    field[wr_ptr] <= in_field;
`endif
                end
                k <= done ? 4'd0 : k + 4'd1;
                if (done) begin
                    full[wr_ptr] <= 1'b1;
                    wr_ptr       <= !wr_ptr;
                end
            end
            // the completing write is bypassed so the first output follows it by one cycle
            if (adv) begin
                out_valid <= avail;
                if (avail) begin
                    out_coeff <= hit ? in_coeff : (mask[ld_ptr][r] ? mem[ld_ptr][r] : '0);
                    out_qp    <= (byp && k == 4'd0) ? in_qp : qp[ld_ptr];
                    out_last  <= r == 4'd15;
                    r         <= r + 4'd1;
                    if (r == 4'd15)
                        ld_ptr <= !ld_ptr;
                end
            end
        end
    end
endmodule

// File: tb/tb_zigzag_coeff_buffer.sv
// tb_zigzag_coeff_buffer: table vectors plus scoreboard-checked multi-block sequences for zigzag_coeff_buffer.
module tb_zigzag_coeff_buffer;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_eob = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_last;
    logic signed [15:0] in_coeff = '0, out_coeff;
    logic [5:0] in_qp = '0, out_qp;

    int errors = 0, checks = 0, stalls = 0, acc_cnt = 0, run = 0, max_run = 0;
    int zz [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

    typedef int arr16_t [16];
    typedef logic [15:0][15:0] blk16_t;
    typedef struct packed { int n; logic [5:0] qp; logic eob; blk16_t c; blk16_t exp; } vec_t;
    typedef struct { int coeff; logic [5:0] qp; logic last; } exp_t;
    exp_t sb [$];
    exp_t e;

    always #5 clk = ~clk;

    zigzag_coeff_buffer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
        .in_eob(in_eob), .in_qp(in_qp),
`ifdef COEFF_FIELD_SCAN_EN
        .in_field(1'b0),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff),
        .out_qp(out_qp), .out_last(out_last)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic blk16_t pk(input arr16_t a);
        blk16_t b;
        for (int j = 0; j < 16; j++) b[j] = 16'(a[j]);
        return b;
    endfunction

    function automatic arr16_t up(input blk16_t b);
        arr16_t a;
        for (int j = 0; j < 16; j++) a[j] = int'($signed(b[j]));
        return a;
    endfunction

    function automatic arr16_t raster(input arr16_t c, input int n);
        arr16_t x;
        for (int j = 0; j < 16; j++) x[j] = 0;
        for (int j = 0; j < n; j++) x[zz[j]] = c[j];
        return x;
    endfunction

    function automatic arr16_t rnd();
        arr16_t x;
        for (int j = 0; j < 16; j++) x[j] = int'($urandom_range(0, 2000)) - 1000;
        return x;
    endfunction

    task automatic put(input int c, input logic eob, input logic [5:0] qp);
        logic rdy;
        int t = 0;
        in_valid = 1'b1; in_coeff = 16'(c); in_eob = eob; in_qp = qp;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            if (!rdy) stalls++;
            @(posedge clk);
            if (rdy) break;
            t++;
            if (t > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        if (rdy) acc_cnt++;
        #1;
        in_valid = 1'b0; in_eob = 1'b0;
    endtask

    task automatic send(input arr16_t c, input int n, input logic [5:0] qp, input logic [5:0] qp_late,
                        input logic eob, input bit push, input arr16_t x);
        for (int j = 0; j < n; j++) put(c[j], eob && j == n - 1, j < 5 ? qp : qp_late);
        if (push)
            for (int j = 0; j < 16; j++) sb.push_back(exp_t'{x[j], qp, j == 15});
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("drain_queue_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) run = 0;
        else begin
            run = out_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got coeff %0d required no output", out_coeff);
                end else begin
                    e = sb.pop_front();
                    if (int'(out_coeff) !== e.coeff || out_qp !== e.qp || out_last !== e.last) begin
                        errors++;
                        $display("FAIL out_data: got coeff=%0d qp=%0d last=%0d required coeff=%0d qp=%0d last=%0d",
                                 out_coeff, out_qp, out_last, e.coeff, e.qp, e.last);
                    end
                end
            end
        end
    end

    vec_t tbl [4];
    arr16_t c, z;
    logic signed [15:0] hc;
    logic [5:0] hq;
    logic hl;
    bit held;
    int unstable;

    initial begin
        tbl[0].n = 16; tbl[0].qp = 28; tbl[0].eob = 1'b0;
        tbl[0].c   = pk('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16});
        tbl[0].exp = pk('{1, 2, 6, 7, 3, 5, 8, 13, 4, 9, 12, 14, 10, 11, 15, 16});
        tbl[1].n = 3; tbl[1].qp = 17; tbl[1].eob = 1'b1;
        tbl[1].c   = pk('{5, -3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl[1].exp = pk('{5, -3, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl[2].n = 1; tbl[2].qp = 63; tbl[2].eob = 1'b1;
        tbl[2].c   = pk('{-9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl[2].exp = pk('{-9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl[3].n = 16; tbl[3].qp = 1; tbl[3].eob = 1'b1;
        tbl[3].c   = pk('{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10, -11, -12, -13, -14, -15, -16});
        tbl[3].exp = pk('{-1, -2, -6, -7, -3, -5, -8, -13, -4, -9, -12, -14, -10, -11, -15, -16});

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_coeff", out_coeff, 0);
        chk("reset_out_qp", out_qp, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stalls = 0;
            send(up(tbl[i].c), tbl[i].n, tbl[i].qp, tbl[i].qp, tbl[i].eob, 1, up(tbl[i].exp));
            chk($sformatf("vec%0d_first_valid_latency", i), out_valid, 1);
            drain();
            chk($sformatf("vec%0d_in_ready_stalls", i), stalls, 0);
        end

        stalls = 0; max_run = 0;
        for (int b = 0; b < 3; b++) begin
            c = rnd();
            send(c, 16, 6'(b + 1), 6'(b + 1), 1'b0, 1, raster(c, 16));
        end
        drain();
        chk("b2b_in_ready_stalls", stalls, 0);
        chk("b2b_valid_run", max_run, 48);

        out_ready = 1'b0; acc_cnt = 0; held = 0; unstable = 0;
        fork
            for (int b = 0; b < 3; b++) begin
                c = rnd();
                send(c, 16, 6'(10 + b), 6'(10 + b), 1'b0, 1, raster(c, 16));
            end
            begin
                repeat (40) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (!held) begin
                            hc = out_coeff; hq = out_qp; hl = out_last; held = 1;
                        end else if (out_coeff !== hc || out_qp !== hq || out_last !== hl) unstable++;
                    end
                end
                chk("stall_accepts", acc_cnt, 32);
                chk("stall_in_ready_low", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_hold_unstable", unstable, 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        c = rnd();
        send(c, 16, 6'd28, 6'd40, 1'b0, 1, raster(c, 16));
        drain();

        out_ready = 1'b0;
        for (int j = 0; j < 16; j++) c[j] = 100 + j;
        send(c, 16, 6'd5, 6'd5, 1'b0, 0, c);
        for (int j = 0; j < 7; j++) put(200 + j, 1'b0, 6'd7);
        chk("pre_reset_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        sb.delete();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_coeff", out_coeff, 0);
        chk("midrst_out_qp", out_qp, 0);
        chk("midrst_out_last", out_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; out_ready = 1'b1;
        z = '{11, -12, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send(z, 3, 6'd9, 6'd9, 1'b1, 1, raster(z, 3));
        drain();
        c = rnd();
        send(c, 16, 6'd33, 6'd33, 1'b0, 1, raster(c, 16));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
